// File: rtl/taillight_pkg.sv
// Shared types for the tail-light sequencer: state encoding, side patterns and lamp decode.
package taillight_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_L1      = 4'd1,
    ST_L2      = 4'd2,
    ST_L3      = 4'd3,
    ST_R1      = 4'd4,
    ST_R2      = 4'd5,
    ST_R3      = 4'd6,
    ST_HAZ_ON  = 4'd7,
    ST_HAZ_OFF = 4'd8
  } state_e;

  localparam logic [2:0] PAT_OFF   = 3'b000;
  localparam logic [2:0] PAT_STEP1 = 3'b001;
  localparam logic [2:0] PAT_STEP2 = 3'b011;
  localparam logic [2:0] PAT_STEP3 = 3'b111;
  localparam logic [2:0] PAT_ALL   = 3'b111;

  // left = {LC,LB,LA}, right = {RC,RB,RA}; bit 0 is the innermost lamp on each side
  typedef struct packed {
    logic [2:0] left;
    logic [2:0] right;
  } lamps_t;

  // A side not running a turn sequence shows all lamps while braking
  function automatic lamps_t decode_lamps(input state_e st, input logic brake);
    lamps_t l;
    logic   turn_l;
    logic   turn_r;
    l       = '{left: PAT_OFF, right: PAT_OFF};
    turn_l  = 1'b0;
    turn_r  = 1'b0;
    case (st)
      ST_L1:      begin l.left  = PAT_STEP1; turn_l = 1'b1; end
      ST_L2:      begin l.left  = PAT_STEP2; turn_l = 1'b1; end
      ST_L3:      begin l.left  = PAT_STEP3; turn_l = 1'b1; end
      ST_R1:      begin l.right = PAT_STEP1; turn_r = 1'b1; end
      ST_R2:      begin l.right = PAT_STEP2; turn_r = 1'b1; end
      ST_R3:      begin l.right = PAT_STEP3; turn_r = 1'b1; end
      ST_HAZ_ON:  begin l.left  = PAT_ALL;   l.right = PAT_ALL; end
      default:    l = '{left: PAT_OFF, right: PAT_OFF};
    endcase
    if (brake) begin
      if (!turn_l) l.left  = PAT_ALL;
      if (!turn_r) l.right = PAT_ALL;
    end
    return l;
  endfunction

endpackage

// File: rtl/taillight_if.sv
// Switch requests in, lamp drives and status out, between board top and taillight_ctrl.
interface taillight_if;
  logic Left;
  logic Right;
  logic Hazard;
  logic Brake;
  logic LA, LB, LC;
  logic RA, RB, RC;
  logic Tick;
  logic Busy;

  modport master (
    output Left, Right, Hazard, Brake,
    input  LA, LB, LC, RA, RB, RC, Tick, Busy
  );

  modport slave (
    input  Left, Right, Hazard, Brake,
    output LA, LB, LC, RA, RB, RC, Tick, Busy
  );
endinterface

// File: rtl/taillight_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, first tick TICK_DIV cycles after reset.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic Clk,
  input  logic Rst,
  output logic o_tick_c
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_count;

  assign o_tick_c = (r_count == CW'(TICK_DIV - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)           r_count <= '0;
    else if (o_tick_c) r_count <= '0;
    else               r_count <= r_count + CW'(1);
  end

endmodule

// File: rtl/taillight_ctrl.sv
// Tail-light sequencer: synchronised requests, tick-enabled FSM, registered lamp decode.
// Define TAILLIGHT_BRAKE_EN to overlay the brake light on sides not running a turn.
module taillight_ctrl
  import taillight_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  taillight_if.slave  bus
);

  logic                        w_tick;
  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic                        w_left, w_right, w_hazard, w_brake_s, w_brake_eff;
  logic                        w_hz;
  state_e                      r_state, w_state_nxt, w_state_eff;
  lamps_t                      r_lamps;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .Clk      (Clk),
    .Rst      (Rst),
    .o_tick_c (w_tick)
  );

  // Per-input synchroniser chain; bit order {Brake, Hazard, Right, Left}
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], {bus.Brake, bus.Hazard, bus.Right, bus.Left}};
  end

  assign {w_brake_s, w_hazard, w_right, w_left} = r_sync[SYNC_STAGES-1];
  assign w_hz = w_hazard | (w_left & w_right);

`ifdef TAILLIGHT_BRAKE_EN
  assign w_brake_eff = w_brake_s;
`else
  logic w_unused_brake;
  assign w_unused_brake = w_brake_s;
  assign w_brake_eff    = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)         r_state <= ST_IDLE;
    else if (w_tick) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if      (w_hz)    w_state_nxt = ST_HAZ_ON;
        else if (w_left)  w_state_nxt = ST_L1;
        else if (w_right) w_state_nxt = ST_R1;
      end
      ST_L1: begin
        if      (w_hz)    w_state_nxt = ST_HAZ_ON;
        else if (w_left)  w_state_nxt = ST_L2;
      end
      ST_L2: begin
        if      (w_hz)    w_state_nxt = ST_HAZ_ON;
        else if (w_left)  w_state_nxt = ST_L3;
      end
      ST_R1: begin
        if      (w_hz)    w_state_nxt = ST_HAZ_ON;
        else if (w_right) w_state_nxt = ST_R2;
      end
      ST_R2: begin
        if      (w_hz)    w_state_nxt = ST_HAZ_ON;
        else if (w_right) w_state_nxt = ST_R3;
      end
      ST_L3, ST_R3, ST_HAZ_OFF: begin
        if (w_hz) w_state_nxt = ST_HAZ_ON;
      end
      ST_HAZ_ON: begin
        if (w_hz) w_state_nxt = ST_HAZ_OFF;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lamps follow the state being loaded, so they change on the same edge as the state
  assign w_state_eff = w_tick ? w_state_nxt : r_state;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_lamps <= '0;
    else     r_lamps <= decode_lamps(w_state_eff, w_brake_eff);
  end

  assign bus.LA   = r_lamps.left[0];
  assign bus.LB   = r_lamps.left[1];
  assign bus.LC   = r_lamps.left[2];
  assign bus.RA   = r_lamps.right[0];
  assign bus.RB   = r_lamps.right[1];
  assign bus.RC   = r_lamps.right[2];
  assign bus.Tick = w_tick;
  assign bus.Busy = (r_state != ST_IDLE);

endmodule
